// File: rtl/osd_regaccess_if.sv
// osd_regaccess_if: request/response flit streams plus the register access bus
// of the OSD register-access FSM. The slave modport is the FSM side, the
// master modport is the environment side (packet source/sink and register file).
interface osd_regaccess_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;

    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    logic        reg_request;
    logic        reg_write;
    logic [15:0] reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output out_data, out_valid, out_last,
        input  out_ready,
        output reg_request, reg_write, reg_addr, reg_wdata,
        input  reg_ack, reg_err, reg_rdata
    );

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  out_data, out_valid, out_last,
        output out_ready,
        input  reg_request, reg_write, reg_addr, reg_wdata,
        output reg_ack, reg_err, reg_rdata
    );
endinterface

// File: rtl/osd_regaccess_fsm.sv
// osd_regaccess_fsm: decodes register read/write request packets, performs the
// register access and returns a response packet to the requester.
// Optional feature: define OSD_REGACCESS_TIMEOUT_EN to abort a register access
// that is not acknowledged within TIMEOUT cycles (answered as an error).
module osd_regaccess_fsm #(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           id,
    osd_regaccess_if.slave        bus
);

    typedef enum logic [3:0] {
        IDLE, SRC, HDR, ADDR, WDATA, ACCESS,
        R_DEST, R_SRC, R_HDR, R_DATA, DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] src_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        is_write_q;

    logic        in_ready_int;
    logic        in_xfer;
    logic        hdr_ok;
    logic        read_ok;
    logic        timeout_hit;

    assign in_ready_int = (state == IDLE) || (state == SRC) || (state == HDR) ||
                          (state == ADDR) || (state == WDATA) || (state == DRAIN);
    assign in_xfer      = bus.in_valid && in_ready_int;
    assign hdr_ok       = (bus.in_data[15:14] == 2'b00) && (bus.in_data[13:11] == 3'b000);
    assign read_ok      = !is_write_q && !err_q;

`ifdef OSD_REGACCESS_TIMEOUT_EN
    localparam logic [7:0] timeout_last = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // Count ACCESS cycles without an acknowledge; cleared outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'h0;
        end else if (state == ACCESS && !bus.reg_ack) begin
            wait_cnt <= wait_cnt + 8'h1;
        end else begin
            wait_cnt <= 8'h0;
        end
    end

    assign timeout_hit = (state == ACCESS) && !bus.reg_ack && (wait_cnt == timeout_last);
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: packet parsing, access wait and response sequencing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_xfer) state_next = bus.in_last ? IDLE : SRC;
            SRC:    if (in_xfer) state_next = bus.in_last ? IDLE : HDR;
            HDR:    if (in_xfer) state_next = bus.in_last ? IDLE : (hdr_ok ? ADDR : DRAIN);
            ADDR: begin
                if (in_xfer) begin
                    if (is_write_q) state_next = bus.in_last ? IDLE : WDATA;
                    else            state_next = bus.in_last ? ACCESS : DRAIN;
                end
            end
            WDATA:  if (in_xfer) state_next = bus.in_last ? ACCESS : DRAIN;
            ACCESS: if (bus.reg_ack || timeout_hit) state_next = R_DEST;
            R_DEST: if (bus.out_ready) state_next = R_SRC;
            R_SRC:  if (bus.out_ready) state_next = R_HDR;
            R_HDR:  if (bus.out_ready) state_next = read_ok ? R_DATA : IDLE;
            R_DATA: if (bus.out_ready) state_next = IDLE;
            DRAIN:  if (in_xfer && bus.in_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture request fields and the access result as the packet streams by.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= 16'h0;
            addr_q     <= 16'h0;
            wdata_q    <= 16'h0;
            rdata_q    <= 16'h0;
            err_q      <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            case (state)
                SRC:   if (in_xfer) src_q      <= bus.in_data;
                HDR:   if (in_xfer) is_write_q <= bus.in_data[10];
                ADDR:  if (in_xfer) addr_q     <= bus.in_data;
                WDATA: if (in_xfer) wdata_q    <= bus.in_data;
                ACCESS: begin
                    if (bus.reg_ack) begin
                        rdata_q <= bus.reg_rdata;
                        err_q   <= bus.reg_err;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state; in_ready is held low during reset.
    always_comb begin
        bus.in_ready    = in_ready_int && rst_n;
        bus.out_valid   = 1'b0;
        bus.out_last    = 1'b0;
        bus.out_data    = 16'h0;
        bus.reg_request = 1'b0;
        bus.reg_write   = 1'b0;
        case (state)
            ACCESS: begin
                bus.reg_request = 1'b1;
                bus.reg_write   = is_write_q;
            end
            R_DEST: begin
                bus.out_valid = 1'b1;
                bus.out_data  = src_q;
            end
            R_SRC: begin
                bus.out_valid = 1'b1;
                bus.out_data  = id;
            end
            R_HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = {2'b00, 1'b1, err_q, is_write_q, 1'b0, 10'b0};
                bus.out_last  = !read_ok;
            end
            R_DATA: begin
                bus.out_valid = 1'b1;
                bus.out_data  = rdata_q;
                bus.out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;

endmodule

// File: tb/tb_osd_regaccess_fsm.sv
// tb_osd_regaccess_fsm: directed test of osd_regaccess_fsm request parsing,
// register access and response generation. The timeout scenario is compiled
// in only when OSD_REGACCESS_TIMEOUT_EN is defined.
module tb_osd_regaccess_fsm;

    localparam logic [15:0] ID = 16'h0042;

    typedef logic [15:0] flit_arr_t [6];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    osd_regaccess_if bus();

    osd_regaccess_fsm #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .id    (ID),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Offer one request flit and wait (bounded) for it to be accepted.
    task automatic sendFlit(input logic [15:0] d, input logic l);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready", 16'(bus.in_ready), 16'h1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 16'h0;
    endtask

    // Send a request packet; in_last accompanies flit number lastIdx.
    task automatic applyStimulus(input flit_arr_t flits, input int count, input int lastIdx);
        for (int i = 0; i < count; i++) begin
            sendFlit(flits[i], (i == lastIdx));
        end
    endtask

    // Wait for the access, check the bus, then acknowledge after delay cycles.
    task automatic runAccess(input int delay, input logic [15:0] rdata, input logic err,
                             input logic expWrite, input logic [15:0] expAddr,
                             input logic [15:0] expWdata, input bit checkWdata);
        int n = 0;
        while (bus.reg_request !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reg_request", 16'(bus.reg_request), 16'h1);
        checkOutput("reg_write", 16'(bus.reg_write), 16'(expWrite));
        checkOutput("reg_addr", bus.reg_addr, expAddr);
        if (checkWdata) checkOutput("reg_wdata", bus.reg_wdata, expWdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput("req_hold", 16'(bus.reg_request), 16'h1);
            checkOutput("addr_hold", bus.reg_addr, expAddr);
            if (checkWdata) checkOutput("wdata_hold", bus.reg_wdata, expWdata);
        end
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = rdata;
        bus.reg_err   = err;
        @(negedge clk);
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 16'h0;
        bus.reg_err   = 1'b0;
        checkOutput("req_drop", 16'(bus.reg_request), 16'h0);
    endtask

    // Receive one response flit, optionally holding out_ready low for stall cycles.
    task automatic recvFlit(input string tag, input logic [15:0] exp, input logic expLast, input int stall);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, 16'(bus.out_valid), 16'h1);
        for (int i = 0; i < stall; i++) begin
            checkOutput({tag, "_stall_data"}, bus.out_data, exp);
            checkOutput({tag, "_stall_in_ready"}, 16'(bus.in_ready), 16'h0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        checkOutput({tag, "_data"}, bus.out_data, exp);
        checkOutput({tag, "_last"}, 16'(bus.out_last), 16'(expLast));
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // Receive a full response; the data flit exists only for successful reads.
    task automatic expectResponse(input logic [15:0] src, input logic [15:0] hdr,
                                  input logic [15:0] data, input bit hasData);
        recvFlit("r_dest", src, 1'b0, 0);
        recvFlit("r_src", ID, 1'b0, 0);
        recvFlit("r_hdr", hdr, !hasData, 0);
        if (hasData) recvFlit("r_data", data, 1'b1, 0);
    endtask

    // Confirm nothing is emitted and no access is started for some cycles.
    task automatic checkQuiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            checkOutput({tag, "_out_valid"}, 16'(bus.out_valid), 16'h0);
            checkOutput({tag, "_reg_request"}, 16'(bus.reg_request), 16'h0);
            @(negedge clk);
        end
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        int n;
        bus.in_data   = 16'h0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        bus.reg_ack   = 1'b0;
        bus.reg_err   = 1'b0;
        bus.reg_rdata = 16'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 16'(bus.in_ready), 16'h0);
        checkOutput("rst_out_valid", 16'(bus.out_valid), 16'h0);
        checkOutput("rst_out_last", 16'(bus.out_last), 16'h0);
        checkOutput("rst_reg_request", 16'(bus.reg_request), 16'h0);
        checkOutput("rst_reg_write", 16'(bus.reg_write), 16'h0);
        checkOutput("rst_out_data", bus.out_data, 16'h0);
        checkOutput("rst_reg_addr", bus.reg_addr, 16'h0);
        checkOutput("rst_reg_wdata", bus.reg_wdata, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 16'(bus.in_ready), 16'h1);

        $display("[TB] read, ack after one cycle");
        applyStimulus('{16'h0001, 16'h0005, 16'h0000, 16'h0200, 16'h0, 16'h0}, 4, 3);
        runAccess(1, 16'hABCD, 1'b0, 1'b0, 16'h0200, 16'h0, 1'b0);
        expectResponse(16'h0005, 16'h2000, 16'hABCD, 1'b1);
        checkQuiet("after_read", 1);

        $display("[TB] write with error");
        applyStimulus('{16'h0001, 16'h0007, 16'h0400, 16'h0203, 16'h1234, 16'h0}, 5, 4);
        runAccess(2, 16'h0, 1'b1, 1'b1, 16'h0203, 16'h1234, 1'b1);
        expectResponse(16'h0007, 16'h3800, 16'h0, 1'b0);

        $display("[TB] write ok");
        applyStimulus('{16'h0001, 16'h0009, 16'h0400, 16'h0010, 16'hBEEF, 16'h0}, 5, 4);
        runAccess(0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
        expectResponse(16'h0009, 16'h2800, 16'h0, 1'b0);

        $display("[TB] read with error");
        applyStimulus('{16'h0001, 16'h000A, 16'h0000, 16'h0300, 16'h0, 16'h0}, 4, 3);
        runAccess(0, 16'h7777, 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0);
        expectResponse(16'h000A, 16'h3000, 16'h0, 1'b0);

        $display("[TB] unsupported type drained, then normal read");
        applyStimulus('{16'h0001, 16'h0005, 16'h4000, 16'h1111, 16'h2222, 16'h3333}, 6, 5);
        checkQuiet("bad_type", 4);
        applyStimulus('{16'h0001, 16'h000B, 16'h0000, 16'h0201, 16'h0, 16'h0}, 4, 3);
        runAccess(0, 16'h5A5A, 1'b0, 1'b0, 16'h0201, 16'h0, 1'b0);
        expectResponse(16'h000B, 16'h2000, 16'h5A5A, 1'b1);

        $display("[TB] read with early last on header");
        applyStimulus('{16'h0001, 16'h0005, 16'h0000, 16'h0, 16'h0, 16'h0}, 3, 2);
        checkOutput("early_last_idle", 16'(bus.in_ready), 16'h1);
        checkQuiet("early_last", 4);

        $display("[TB] read missing last, extra flit drained");
        applyStimulus('{16'h0001, 16'h0005, 16'h0000, 16'h0200, 16'hFFFF, 16'h0}, 5, 4);
        checkQuiet("missing_last", 3);

        $display("[TB] stray ack while idle");
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = 16'hDEAD;
        @(negedge clk);
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 16'h0;
        checkQuiet("stray_ack", 3);

        $display("[TB] response stalled in R_SRC");
        applyStimulus('{16'h0001, 16'h000C, 16'h0000, 16'h0202, 16'h0, 16'h0}, 4, 3);
        runAccess(0, 16'h1357, 1'b0, 1'b0, 16'h0202, 16'h0, 1'b0);
        recvFlit("stall_dest", 16'h000C, 1'b0, 0);
        recvFlit("stall_src", ID, 1'b0, 10);
        recvFlit("stall_hdr", 16'h2000, 1'b0, 0);
        recvFlit("stall_data", 16'h1357, 1'b1, 0);

        $display("[TB] reset during access");
        applyStimulus('{16'h0001, 16'h000E, 16'h0000, 16'h0205, 16'h0, 16'h0}, 4, 3);
        checkOutput("pre_reset_req", 16'(bus.reg_request), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_req", 16'(bus.reg_request), 16'h0);
        rst_n = 1'b1;
        checkQuiet("post_reset", 5);
        applyStimulus('{16'h0001, 16'h000F, 16'h0000, 16'h0206, 16'h0, 16'h0}, 4, 3);
        runAccess(0, 16'h2468, 1'b0, 1'b0, 16'h0206, 16'h0, 1'b0);
        expectResponse(16'h000F, 16'h2000, 16'h2468, 1'b1);

`ifdef OSD_REGACCESS_TIMEOUT_EN
        $display("[TB] access timeout");
        applyStimulus('{16'h0001, 16'h000D, 16'h0000, 16'h0204, 16'h0, 16'h0}, 4, 3);
        n = 0;
        while (bus.reg_request === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("timeout_cycles", 16'(n), 16'd4);
        expectResponse(16'h000D, 16'h3000, 16'h0, 1'b0);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
